// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its IF/ID hold buffer.
// COUNT_WIDTH matches the width of the Pc stage statistics counters.
package fetch_stage_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0000;
    localparam int COUNT_WIDTH = 25;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HOLD = 1'b1
    } fetchState_t;

endpackage

// File: rtl/fetch_stage_hold_buffer.sv
// IF/ID hold registers and the output mux selecting the live ROM word or the held slot.
// The held slot is captured when decode stalls and can be killed by a redirect.
module fetch_hold_buffer
    import fetch_stage_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  fetchState_t            state,
    input  logic                   capture,
    input  logic                   kill,
    input  logic                   captureValid,
    input  logic [INSTR_WIDTH-1:0] romData,
    input  logic [31:0]            pcF,
    input  logic                   validF,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [31:0]            pcOut,
    output logic                   valid,
    output logic                   holdValid
);

    logic [INSTR_WIDTH-1:0] holdInstr;
    logic [31:0]            holdPc;

    always_ff @(posedge clock) begin
        if (reset) begin
            holdInstr <= NOP_INSTR;
            holdPc    <= 32'd0;
            holdValid <= 1'b0;
        end else if (capture) begin
            holdInstr <= romData;
            holdPc    <= pcF;
            holdValid <= captureValid;
        end else if (kill) begin
            holdValid <= 1'b0;
        end
    end

    always_comb begin
        instruction = romData;
        pcOut       = pcF;
        valid       = validF;
        if (state == FETCH_HOLD) begin
            instruction = holdInstr;
            pcOut       = holdPc;
            valid       = holdValid;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch and IF/ID boundary: drives the sync ROM address, pairs the returned word
// with its PC, holds under decode stall, kills wrong-path slots and keeps fetch/flush statistics.
module fetch_stage #(
    parameter int ADDR_WIDTH  = 10,
    parameter int COUNT_WIDTH = fetch_stage_pkg::COUNT_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [31:0]            pc,
    input  logic                   jumped,
    input  logic                   stall,
    output logic [ADDR_WIDTH-1:0]  romAddr,
    input  logic [31:0]            romData,
    output logic [31:0]            instruction,
    output logic [31:0]            pcOut,
    output logic [31:0]            nextPc,
    output logic                   valid,
    output logic                   misaligned,
    output logic [COUNT_WIDTH-1:0] fetchedCount,
    output logic [COUNT_WIDTH-1:0] flushedCount
);

    import fetch_stage_pkg::*;

    fetchState_t state;
    fetchState_t nextState;
    logic [31:0] pcF;
    logic        validF;
    logic        loadFetch;
    logic        clearValidF;
    logic        capture;
    logic        kill;
    logic        flushInc;
    logic        captureValid;
    logic        holdValid;
    logic        consume;
    logic        misSet;

    assign romAddr      = pc[ADDR_WIDTH+1:2];
    assign nextPc       = pcOut + 32'd4;
    assign captureValid = validF & ~jumped;
    assign consume      = enable & ~stall & valid;
    assign misSet       = enable & (state == FETCH_RUN) & (pc[1:0] != 2'b00);

    // A redirect while held also kills the frozen fetch slot, so it cannot reappear on release.
    always_comb begin
        nextState   = state;
        loadFetch   = 1'b0;
        clearValidF = 1'b0;
        capture     = 1'b0;
        kill        = 1'b0;
        flushInc    = 1'b0;
        if (enable) begin
            case (state)
                FETCH_RUN: begin
                    flushInc = jumped;
                    if (stall) begin
                        capture   = 1'b1;
                        nextState = FETCH_HOLD;
                    end else begin
                        loadFetch = 1'b1;
                    end
                end
                FETCH_HOLD: begin
                    if (jumped) begin
                        kill        = 1'b1;
                        clearValidF = 1'b1;
                        flushInc    = holdValid;
                    end
                    if (!stall) begin
                        nextState = FETCH_RUN;
                    end
                end
                default: nextState = FETCH_RUN;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= FETCH_RUN;
            pcF          <= 32'd0;
            validF       <= 1'b0;
            misaligned   <= 1'b0;
            fetchedCount <= '0;
            flushedCount <= '0;
        end else if (enable) begin
            state <= nextState;
            if (loadFetch) begin
                pcF    <= pc;
                validF <= ~jumped;
            end else if (clearValidF) begin
                validF <= 1'b0;
            end
            if (consume) begin
                fetchedCount <= fetchedCount + 1'b1;
            end
            if (flushInc) begin
                flushedCount <= flushedCount + 1'b1;
            end
            if (misSet) begin
                misaligned <= 1'b1;
            end
        end
    end

    fetch_hold_buffer u_holdBuffer (
        .clock        (clock),
        .reset        (reset),
        .state        (state),
        .capture      (capture),
        .kill         (kill),
        .captureValid (captureValid),
        .romData      (romData),
        .pcF          (pcF),
        .validF       (validF),
        .instruction  (instruction),
        .pcOut        (pcOut),
        .valid        (valid),
        .holdValid    (holdValid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural sync ROM and an expected-output queue.
// Counters are narrowed so the wrap boundary is reachable in a short run.
module tb_fetch_stage;

    localparam int AW = 10;
    localparam int CW = 8;

    typedef struct {
        string       tag;
        logic [31:0] pcOut;
        logic [31:0] instr;
        bit          chkInstr;
        logic        valid;
        logic [CW-1:0] fetched;
        logic [CW-1:0] flushed;
        logic        mis;
    } expect_t;

    logic          clock;
    logic          reset;
    logic          enable;
    logic [31:0]   pc;
    logic          jumped;
    logic          stall;
    logic [AW-1:0] romAddr;
    logic [31:0]   romData;
    logic [31:0]   instruction;
    logic [31:0]   pcOut;
    logic [31:0]   nextPc;
    logic          valid;
    logic          misaligned;
    logic [CW-1:0] fetchedCount;
    logic [CW-1:0] flushedCount;

    logic [31:0]   rom [0:(1<<AW)-1];
    expect_t       sbQueue[$];
    int            compared;
    int            mismatched;
    logic [CW-1:0] expFetched;
    logic [CW-1:0] expFlushed;
    logic          curValid;

    fetch_stage #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .pc           (pc),
        .jumped       (jumped),
        .stall        (stall),
        .romAddr      (romAddr),
        .romData      (romData),
        .instruction  (instruction),
        .pcOut        (pcOut),
        .nextPc       (nextPc),
        .valid        (valid),
        .misaligned   (misaligned),
        .fetchedCount (fetchedCount),
        .flushedCount (flushedCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) romData <= rom[romAddr];

    task automatic checkField(input string tag, input string name, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s/%s observed=%h expected=%h", tag, name, obs, exp);
        end
    endtask

    task automatic checkOutput();
        expect_t e;
        if (sbQueue.size() == 0) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL scoreboard empty observed=0 expected=1");
            return;
        end
        e = sbQueue.pop_front();
        checkField(e.tag, "pcOut", pcOut, e.pcOut);
        checkField(e.tag, "nextPc", nextPc, e.pcOut + 32'd4);
        checkField(e.tag, "valid", {31'd0, valid}, {31'd0, e.valid});
        if (e.chkInstr) checkField(e.tag, "instruction", instruction, e.instr);
        checkField(e.tag, "fetchedCount", {{(32-CW){1'b0}}, fetchedCount}, {{(32-CW){1'b0}}, e.fetched});
        checkField(e.tag, "flushedCount", {{(32-CW){1'b0}}, flushedCount}, {{(32-CW){1'b0}}, e.flushed});
        checkField(e.tag, "misaligned", {31'd0, misaligned}, {31'd0, e.mis});
    endtask

    task automatic applyStimulus(input string tag, input logic rst, input logic en,
                                 input logic [31:0] pcIn, input logic jmp, input logic stl,
                                 input logic [31:0] expPc, input logic [31:0] expInstr,
                                 input bit chkInstr, input logic expValid,
                                 input int flushInc, input logic expMis);
        expect_t e;
        reset  = rst;
        enable = en;
        pc     = pcIn;
        jumped = jmp;
        stall  = stl;
        #1;
        checkField(tag, "romAddr", {{(32-AW){1'b0}}, romAddr}, {{(32-AW){1'b0}}, pcIn[AW+1:2]});
        if (rst) begin
            expFetched = '0;
            expFlushed = '0;
        end else if (en) begin
            if (!stl && curValid) expFetched = expFetched + 1'b1;
            expFlushed = expFlushed + CW'(flushInc);
        end
        e.tag      = tag;
        e.pcOut    = expPc;
        e.instr    = expInstr;
        e.chkInstr = chkInstr;
        e.valid    = expValid;
        e.fetched  = expFetched;
        e.flushed  = expFlushed;
        e.mis      = expMis;
        sbQueue.push_back(e);
        @(posedge clock);
        #1;
        checkOutput();
        curValid = expValid;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        expFetched = '0;
        expFlushed = '0;
        curValid   = 1'b0;
        romData    = 32'd0;
        for (int i = 0; i < (1 << AW); i++) rom[i] = 32'hA000_0000 + 32'(i);
        rom[0] = 32'h2008_0005;

        //            tag          rst  en  pc       jmp  stl  expPc    expInstr        chk valid fl mis
        applyStimulus("reset",     1, 1, 32'h0,  0, 0, 32'h0,  32'h0,          0, 0, 0, 0);
        applyStimulus("seq0",      0, 1, 32'h0,  0, 0, 32'h0,  32'h2008_0005,  1, 1, 0, 0);
        applyStimulus("seq4",      0, 1, 32'h4,  0, 0, 32'h4,  32'hA000_0001,  1, 1, 0, 0);
        applyStimulus("seq8",      0, 1, 32'h8,  0, 0, 32'h8,  32'hA000_0002,  1, 1, 0, 0);
        applyStimulus("seq12",     0, 1, 32'hC,  0, 0, 32'hC,  32'hA000_0003,  1, 1, 0, 0);
        applyStimulus("redirect",  0, 1, 32'h10, 1, 0, 32'h10, 32'hA000_0004,  1, 0, 1, 0);
        applyStimulus("target",    0, 1, 32'h40, 0, 0, 32'h40, 32'hA000_0010,  1, 1, 0, 0);
        applyStimulus("pre_stall", 0, 1, 32'h8,  0, 0, 32'h8,  32'hA000_0002,  1, 1, 0, 0);
        applyStimulus("stall1",    0, 1, 32'h8,  0, 1, 32'h8,  32'hA000_0002,  1, 1, 0, 0);
        rom[2] = 32'hDEAD_BEEF;
        applyStimulus("stall2",    0, 1, 32'h8,  0, 1, 32'h8,  32'hA000_0002,  1, 1, 0, 0);
        applyStimulus("stall3",    0, 1, 32'h8,  0, 1, 32'h8,  32'hA000_0002,  1, 1, 0, 0);
        applyStimulus("release",   0, 1, 32'h8,  0, 0, 32'h8,  32'hDEAD_BEEF,  1, 1, 0, 0);
        applyStimulus("after_rel", 0, 1, 32'hC,  0, 0, 32'hC,  32'hA000_0003,  1, 1, 0, 0);
        applyStimulus("hold_in",   0, 1, 32'h10, 0, 1, 32'hC,  32'hA000_0003,  1, 1, 0, 0);
        applyStimulus("hold_jump", 0, 1, 32'h10, 1, 1, 32'hC,  32'hA000_0003,  1, 0, 1, 0);
        applyStimulus("hold_keep", 0, 1, 32'h80, 0, 1, 32'hC,  32'hA000_0003,  1, 0, 0, 0);
        applyStimulus("frozen1",   0, 0, 32'h80, 1, 1, 32'hC,  32'hA000_0003,  1, 0, 0, 0);
        applyStimulus("frozen2",   0, 0, 32'h80, 0, 0, 32'hC,  32'hA000_0003,  1, 0, 0, 0);
        applyStimulus("reset_mid", 1, 1, 32'h0,  0, 0, 32'h0,  32'h0,          0, 0, 0, 0);
        applyStimulus("misalign",  0, 1, 32'h6,  0, 0, 32'h6,  32'hA000_0001,  1, 1, 0, 1);
        applyStimulus("sticky",    0, 1, 32'h8,  0, 0, 32'h8,  32'hDEAD_BEEF,  1, 1, 0, 1);

        for (int k = 0; k < 255; k++) begin
            applyStimulus("wrap", 0, 1, 32'hC + 32'(k) * 32'd4, 0, 0, 32'hC + 32'(k) * 32'd4,
                          32'hA000_0003 + 32'(k), 1, 1, 0, 1);
        end
        checkField("wrap", "fetchedCountZero", {{(32-CW){1'b0}}, fetchedCount}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
